// File: rtl/tx_stream_arbiter.sv
// rtl/tx_stream_arbiter.sv - four-way round-robin arbiter with burst lock onto one transmit stream
//
// Ports:
//   clk               sole clock, all state on the rising edge
//   rst               asynchronous active-low reset
//   exception         sticky: a granted word waited TIMEOUT cycles for output_out_ack
//   input_N           requester N data word (N = 0..3), stable while input_N_stb is high
//   input_N_stb       requester N word valid
//   input_N_ack       one-cycle pulse in the first SEND cycle: requester N word taken
//   output_out        granted word, held while output_out_stb is high
//   output_out_stb    output word valid (high for the whole SEND state)
//   output_out_ack    downstream consumed the word
//   output_src        index of the requester whose word is on output_out

module tx_stream_arbiter #(
    parameter int WIDTH   = 32,
    parameter int BURST   = 1,
    parameter int TIMEOUT = 1023
) (
    input  logic             clk,
    input  logic             rst,
    output logic             exception,
    input  logic [WIDTH-1:0] input_0,
    input  logic             input_0_stb,
    output logic             input_0_ack,
    input  logic [WIDTH-1:0] input_1,
    input  logic             input_1_stb,
    output logic             input_1_ack,
    input  logic [WIDTH-1:0] input_2,
    input  logic             input_2_stb,
    output logic             input_2_ack,
    input  logic [WIDTH-1:0] input_3,
    input  logic             input_3_stb,
    output logic             input_3_ack,
    output logic [WIDTH-1:0] output_out,
    output logic             output_out_stb,
    input  logic             output_out_ack,
    output logic [1:0]       output_src
);

    localparam int              TW            = (TIMEOUT > 65535) ? 32 : 16;
    localparam logic [7:0]      BURST_LIMIT   = 8'(BURST);
    localparam logic [TW-1:0]   TIMEOUT_LIMIT = TW'(TIMEOUT);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [3:0]       stb_vec;
    logic [WIDTH-1:0] data_vec [4];

    logic [1:0]       last_grant;
    // No word has completed since reset, so there is no requester to lock onto.
    logic             prev_valid;
    logic [7:0]       burst_cnt;
    logic [TW-1:0]    tmo_cnt;
    logic [TW-1:0]    tmo_next;
    logic [3:0]       ack_q;

    logic [1:0]       rr_idx;
    logic             lock_hit;
    logic             sel_valid;
    logic [1:0]       sel_idx;
    logic             tmo_count_en;
    logic             tmo_hit;

    always_comb begin
        stb_vec     = {input_3_stb, input_2_stb, input_1_stb, input_0_stb};
        data_vec[0] = input_0;
        data_vec[1] = input_1;
        data_vec[2] = input_2;
        data_vec[3] = input_3;
    end

    // Round-robin scan starting just after the last granted requester; the
    // fourth step wraps back onto last_grant itself.
    always_comb begin
        logic       found;
        logic [1:0] cand;
        rr_idx = last_grant;
        found  = 1'b0;
        cand   = last_grant;
        for (int i = 1; i <= 4; i++) begin
            cand = last_grant + 2'(i);
            if (!found && stb_vec[cand]) begin
                rr_idx = cand;
                found  = 1'b1;
            end
        end
    end

    // The previous requester keeps the grant while it still has a word ready
    // and has not used up its burst allowance.
    assign lock_hit = prev_valid && (burst_cnt < BURST_LIMIT) && stb_vec[last_grant];

    always_comb begin
        state_nxt = state;
        sel_valid = 1'b0;
        sel_idx   = rr_idx;
        case (state)
            IDLE: begin
                if (|stb_vec) begin
                    sel_valid = 1'b1;
                    sel_idx   = lock_hit ? last_grant : rr_idx;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (output_out_ack) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The timeout counter only advances while a word is waiting and stops at
    // the limit, so the sticky flag is raised exactly once per stalled word.
    assign tmo_next     = tmo_cnt + 1'b1;
    assign tmo_count_en = (TIMEOUT != 0) && (state == SEND) && !output_out_ack
                          && (tmo_cnt != TIMEOUT_LIMIT);
    assign tmo_hit      = tmo_count_en && (tmo_next == TIMEOUT_LIMIT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            output_out <= '0;
            output_src <= 2'd0;
            ack_q      <= 4'b0000;
            exception  <= 1'b0;
            last_grant <= 2'd3;
            prev_valid <= 1'b0;
            burst_cnt  <= 8'd0;
            tmo_cnt    <= '0;
        end else begin
            ack_q <= 4'b0000;

            if (sel_valid) begin
                output_out <= data_vec[sel_idx];
                output_src <= sel_idx;
                ack_q      <= 4'b0001 << sel_idx;
                tmo_cnt    <= '0;
                if (!lock_hit) begin
                    burst_cnt <= 8'd0;
                end
            end

            if (state == SEND && output_out_ack) begin
                burst_cnt  <= burst_cnt + 8'd1;
                last_grant <= output_src;
                prev_valid <= 1'b1;
            end

            if (tmo_count_en) begin
                tmo_cnt <= tmo_next;
            end

            if (tmo_hit) begin
                exception <= 1'b1;
            end
        end
    end

    assign output_out_stb = (state == SEND);
    assign input_0_ack    = ack_q[0];
    assign input_1_ack    = ack_q[1];
    assign input_2_ack    = ack_q[2];
    assign input_3_ack    = ack_q[3];

endmodule

// File: tb/tb_tx_stream_arbiter.sv
// tb/tb_tx_stream_arbiter.sv - scoreboard bench for tx_stream_arbiter (BURST=1/TIMEOUT=8 and BURST=3/TIMEOUT=0)

module tb_tx_stream_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] rq_data [4];
    logic [3:0]  rq_stb;
    logic        out_ack;

    logic [3:0]  d1_ack;
    logic [31:0] d1_out;
    logic        d1_stb;
    logic [1:0]  d1_src;
    logic        d1_exc;

    logic [3:0]  d3_ack;
    logic [31:0] d3_out;
    logic        d3_stb;
    logic [1:0]  d3_src;
    logic        d3_exc;

    int checks   = 0;
    int failures = 0;

    logic [33:0] q1 [$];
    logic [33:0] q3 [$];
    logic [3:0]  prev_ack1 = 4'b0;
    logic [3:0]  prev_ack3 = 4'b0;

    always #5 clk = ~clk;

    tx_stream_arbiter #(.WIDTH(32), .BURST(1), .TIMEOUT(8)) dut1 (
        .clk(clk), .rst(rst), .exception(d1_exc),
        .input_0(rq_data[0]), .input_0_stb(rq_stb[0]), .input_0_ack(d1_ack[0]),
        .input_1(rq_data[1]), .input_1_stb(rq_stb[1]), .input_1_ack(d1_ack[1]),
        .input_2(rq_data[2]), .input_2_stb(rq_stb[2]), .input_2_ack(d1_ack[2]),
        .input_3(rq_data[3]), .input_3_stb(rq_stb[3]), .input_3_ack(d1_ack[3]),
        .output_out(d1_out), .output_out_stb(d1_stb), .output_out_ack(out_ack),
        .output_src(d1_src)
    );

    tx_stream_arbiter #(.WIDTH(32), .BURST(3), .TIMEOUT(0)) dut3 (
        .clk(clk), .rst(rst), .exception(d3_exc),
        .input_0(rq_data[0]), .input_0_stb(rq_stb[0]), .input_0_ack(d3_ack[0]),
        .input_1(rq_data[1]), .input_1_stb(rq_stb[1]), .input_1_ack(d3_ack[1]),
        .input_2(rq_data[2]), .input_2_stb(rq_stb[2]), .input_2_ack(d3_ack[2]),
        .input_3(rq_data[3]), .input_3_stb(rq_stb[3]), .input_3_ack(d3_ack[3]),
        .output_out(d3_out), .output_out_stb(d3_stb), .output_out_ack(out_ack),
        .output_src(d3_src)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input int src1, input int src3);
        q1.push_back({2'(src1), rq_data[src1]});
        q3.push_back({2'(src3), rq_data[src3]});
    endtask

    task automatic monitor_one(input int id, input logic [3:0] ack, input logic [3:0] prev,
                               input logic [1:0] src, input logic [31:0] data, input logic stb);
        logic [33:0] e;
        if (ack != 4'b0) begin
            check($sformatf("d%0d_ack_onehot", id), 64'($countones(ack)), 64'd1);
            check($sformatf("d%0d_ack_single_cycle", id), 64'(ack & prev), 64'd0);
            check($sformatf("d%0d_ack_vs_src", id), 64'(ack), 64'(4'b0001 << src));
            check($sformatf("d%0d_stb_with_ack", id), 64'(stb), 64'd1);
            if ((id == 1 && q1.size() == 0) || (id == 3 && q3.size() == 0)) begin
                check($sformatf("d%0d_unexpected_grant", id), 64'(ack), 64'd0);
            end else begin
                e = (id == 1) ? q1.pop_front() : q3.pop_front();
                check($sformatf("d%0d_grant_src", id), 64'(src), 64'(e[33:32]));
                check($sformatf("d%0d_grant_data", id), 64'(data), 64'(e[31:0]));
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            monitor_one(1, d1_ack, prev_ack1, d1_src, d1_out, d1_stb);
            monitor_one(3, d3_ack, prev_ack3, d3_src, d3_out, d3_stb);
        end
        prev_ack1 = d1_ack;
        prev_ack3 = d3_ack;
    end

    task automatic wait_drain();
        for (int i = 0; i < 100 && (q1.size() != 0 || q3.size() != 0); i++) begin
            @(posedge clk);
        end
        @(negedge clk);
        check("drain_q1", 64'(q1.size()), 64'd0);
        check("drain_q3", 64'(q3.size()), 64'd0);
        q1.delete();
        q3.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b0;
        rq_stb  = 4'b0;
        out_ack = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Holds mask until n grants have been taken with output_out_ack high
    // (one grant every other edge), then drops the strobes during SEND.
    task automatic run_mask(input logic [3:0] mask, input int n);
        @(negedge clk);
        rq_stb = mask;
        @(posedge clk);
        repeat (2 * n - 2) @(posedge clk);
        #1;
        rq_stb = 4'b0;
        wait_drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int o1 [8];
        int o3 [8];
        rst     = 1'b0;
        rq_stb  = 4'b0;
        out_ack = 1'b1;
        for (int i = 0; i < 4; i++) rq_data[i] = 32'h5500_0000 + 32'(i);
        repeat (2) @(posedge clk);
        #1;
        check("rst_d1_out", 64'(d1_out), 64'd0);
        check("rst_d1_stb", 64'(d1_stb), 64'd0);
        check("rst_d1_src", 64'(d1_src), 64'd0);
        check("rst_d1_ack", 64'(d1_ack), 64'd0);
        check("rst_d1_exc", 64'(d1_exc), 64'd0);
        check("rst_d3_out", 64'(d3_out), 64'd0);
        check("rst_d3_stb", 64'(d3_stb), 64'd0);
        check("rst_d3_exc", 64'(d3_exc), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // Single requester 2, downstream always ready: one word per two cycles.
        rq_data[2] = 32'h1234_5678;
        for (int i = 0; i < 5; i++) push(2, 2);
        @(negedge clk);
        rq_stb = 4'b0100;
        @(posedge clk);
        #1;
        check("lat_d1_ack2", 64'(d1_ack), 64'b0100);
        check("lat_d1_stb", 64'(d1_stb), 64'd1);
        check("lat_d3_ack2", 64'(d3_ack), 64'b0100);
        repeat (8) @(posedge clk);
        #1;
        rq_stb = 4'b0;
        wait_drain();
        repeat (3) @(posedge clk);
        #1;
        check("idle_hold_out", 64'(d1_out), 64'h1234_5678);
        check("idle_hold_src", 64'(d1_src), 64'd2);
        check("idle_stb_low", 64'(d1_stb), 64'd0);

        // All four requesting.
        do_reset();
        for (int i = 0; i < 4; i++) rq_data[i] = 32'hA0A0_0000 + 32'(i * 17);
        o1 = '{0, 1, 2, 3, 0, 1, 2, 3};
        o3 = '{0, 0, 0, 1, 1, 1, 2, 2};
        for (int i = 0; i < 8; i++) push(o1[i], o3[i]);
        run_mask(4'b1111, 8);

        // Requesters 0 and 1 only.
        do_reset();
        for (int i = 0; i < 4; i++) rq_data[i] = 32'hC3C3_0000 ^ 32'(i << 8);
        o1 = '{0, 1, 0, 1, 0, 1, 0, 0};
        o3 = '{0, 0, 0, 1, 1, 1, 0, 0};
        for (int i = 0; i < 7; i++) push(o1[i], o3[i]);
        run_mask(4'b0011, 7);

        // stb_0 drops after its first word: burst lock released.
        do_reset();
        for (int i = 0; i < 4; i++) rq_data[i] = 32'h0BAD_0000 + 32'(i);
        push(0, 0);
        push(1, 1);
        push(1, 1);
        @(negedge clk);
        rq_stb = 4'b0011;
        @(posedge clk);
        #1;
        rq_stb = 4'b0010;
        repeat (4) @(posedge clk);
        #1;
        rq_stb = 4'b0;
        wait_drain();
        check("no_exc_when_acked", 64'(d1_exc), 64'd0);

        // Downstream stalls: timeout raises the sticky exception.
        do_reset();
        rq_data[1] = 32'h7777_1111;
        push(1, 1);
        out_ack = 1'b0;
        @(negedge clk);
        rq_stb = 4'b0010;
        @(posedge clk);
        #1;
        rq_stb = 4'b1000;
        repeat (7) @(posedge clk);
        #1;
        check("exc_before_limit", 64'(d1_exc), 64'd0);
        @(posedge clk);
        #1;
        check("exc_at_limit", 64'(d1_exc), 64'd1);
        check("exc_disabled_d3", 64'(d3_exc), 64'd0);
        rq_stb = 4'b0;
        repeat (4) @(posedge clk);
        #1;
        check("exc_sticky", 64'(d1_exc), 64'd1);
        check("stall_stb_held", 64'(d1_stb), 64'd1);
        check("stall_out_held", 64'(d1_out), 64'h7777_1111);
        @(negedge clk);
        out_ack = 1'b1;
        @(posedge clk);
        #1;
        check("stall_done_stb", 64'(d1_stb), 64'd0);
        check("exc_after_ack", 64'(d1_exc), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        check("exc_still_set", 64'(d1_exc), 64'd1);
        wait_drain();

        // Reset in the middle of SEND.
        do_reset();
        rq_data[0] = 32'hDEAD_BEEF;
        push(0, 0);
        out_ack = 1'b0;
        @(negedge clk);
        rq_stb = 4'b0001;
        @(posedge clk);
        #1;
        rq_stb = 4'b0;
        @(posedge clk);
        #3;
        check("pre_rst_out", 64'(d1_out), 64'hDEAD_BEEF);
        rst = 1'b0;
        #1;
        check("async_rst_out", 64'(d1_out), 64'd0);
        check("async_rst_stb", 64'(d1_stb), 64'd0);
        check("async_rst_src", 64'(d1_src), 64'd0);
        check("async_rst_d3_out", 64'(d3_out), 64'd0);
        check("async_rst_d3_stb", 64'(d3_stb), 64'd0);
        check("mid_send_q_empty", 64'(q1.size()), 64'd0);
        rq_data[1] = 32'h1111_0001;
        rq_stb     = 4'b0011;
        out_ack    = 1'b1;
        push(0, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rq_stb = 4'b0;
        check("post_rst_first_grant", 64'(d1_ack), 64'b0001);
        wait_drain();
        check("post_rst_exc", 64'(d1_exc), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
